// File: rtl/lsu_pkg.sv
// Shared types and constants for the data_mem load/store unit.
package lsu_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned LANE_W     = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_BAD = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE,
    RESP
  } lsu_state_e;

endpackage

// File: rtl/data_mem_lsu_if.sv
// Request/response channel between the datapath (master) and the LSU (slave).
interface data_mem_lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/lsu_lane.sv
// Byte-lane steering: sub-word store merge and load extract/extend.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] wdata,
  input  lsu_size_e         size,
  input  logic [LANE_W-1:0] lane,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] merged,
  output logic [DATA_W-1:0] rdata
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Replace the addressed lane(s) for stores; pick and extend them for loads.
  always_comb begin
    merged = word;
    rdata  = word;
    lane_b = word[{lane, 3'b000} +: 8];
    lane_h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_B: begin
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
        rdata = {{24{sign_ext & lane_b[7]}}, lane_b};
      end
      SZ_H: begin
        merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        rdata = {{16{sign_ext & lane_h[15]}}, lane_h};
      end
      SZ_W: merged = wdata;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store initiator for data_mem: one request in flight, RMW for sub-word stores.
module data_mem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  data_mem_lsu_if.slave      bus,
  output logic               mem_wen,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic              ready_q, ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              wen_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

  logic              write_q, write_d;
  lsu_size_e         size_q, size_d;
  logic              sign_q, sign_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  lsu_size_e         req_size;
  logic              req_err;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] load_data;

  assign req_size      = lsu_size_e'(bus.req_size);
  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  lsu_lane u_lane (
    .word     (mem_rdata),
    .wdata    (hold_q),
    .size     (size_q),
    .lane     (lane_q),
    .sign_ext (sign_q),
    .merged   (merged),
    .rdata    (load_data)
  );

  // Reject illegal size, misalignment and addresses beyond the top word.
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      SZ_H:    req_err = bus.req_addr[0];
      SZ_W:    req_err = |bus.req_addr[1:0];
      SZ_BAD:  req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if (|bus.req_addr[31:ADDR_W+2]) req_err = 1'b1;
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    wen_d       = 1'b0;
    addr_d      = mem_addr;
    wdata_d     = mem_wdata;
    write_d     = write_q;
    size_d      = size_q;
    sign_d      = sign_q;
    lane_d      = lane_q;
    hold_d      = hold_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && ready_q) begin
          if (req_err) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            write_d = bus.req_write;
            size_d  = req_size;
            sign_d  = bus.req_signed;
            lane_d  = bus.req_addr[LANE_W-1:0];
            hold_d  = bus.req_wdata;
            addr_d  = bus.req_addr[ADDR_W+1:2];
            state_d = ACCESS;
            if (bus.req_write && (req_size == SZ_W)) begin
              wen_d   = 1'b1;
              wdata_d = bus.req_wdata;
            end
          end
        end
      end
      ACCESS: begin
        if (!write_q) begin
          rsp_rdata_d = load_data;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (size_q == SZ_W) begin
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          wen_d   = 1'b1;
          wdata_d = merged;
          state_d = WRITE;
        end
      end
      WRITE: begin
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // State, output and latched-request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_wen     <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      write_q     <= 1'b0;
      size_q      <= SZ_B;
      sign_q      <= 1'b0;
      lane_q      <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_wen     <= wen_d;
      mem_addr    <= addr_d;
      mem_wdata   <= wdata_d;
      write_q     <= write_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      lane_q      <= lane_d;
      hold_q      <= hold_d;
    end
  end

endmodule
